wb_stage: RTL
=============

# wb_stage

Writeback stage of the pipelined processor, sitting directly upstream of the register array. It latches one result per cycle from the execute/memory stage and drives the array's write port: data, write selector, and the R0/RN load strobes. It also provides two-level operand forwarding for the array's current read selector. After every reset it issues one clear-all command.

## Interface
- No parameters; data width is fixed at 16 and the register selector is fixed at 3 bits.
- clk  in  1  system-wide clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- ex_valid  in  1  execute stage presents a result this cycle.
- ex_data  in  16  result value.
- ex_dest  in  3  destination register index.
- ex_clear  in  1  result is a clear-all instruction; ex_data and ex_dest are ignored.
- stall  in  1  pipeline freeze; blocks capture.
- flush  in  1  kills the latched result before it writes.
- ex_ready  out  1  stage accepts ex_valid this cycle.
- WB_DataIn  out  16  write data to the register array.
- WB_RegSel  out  3  write selector to the register array.
- L_R0  out  1  R0 load strobe.
- L_RN  out  1  RN load strobe. L_R0 and L_RN asserted together means clear-all.
- rd_regsel  in  3  the array's current read selector, used for forwarding.
- fwd_rn_hit  out  1  fwd_rn_data supersedes the array's RN output.
- fwd_rn_data  out  16  forwarded RN value.
- fwd_r0_hit  out  1  fwd_r0_data supersedes the array's R0 output.
- fwd_r0_data  out  16  forwarded R0 value.
- wb_count  out  16  number of retired writes.

## Operation
- State machine with two states: INIT and RUN.
  - rst forces INIT. The first posedge with rst low moves INIT to RUN.
  - Both states are registered.
- INIT:
  - L_R0 = L_RN = 1, so the array is cleared on that posedge.
  - ex_ready = 0.
  - Forwarding hits are 0.
- RUN:
  - ex_ready = ~stall.
  - Capture occurs when ex_valid & ex_ready. It loads the latch {v=1, clr, dest, data}.
  - Without capture, v clears after one cycle. Each latched entry writes exactly once.
- Write decode. All write outputs are combinational from the latch, gated by v & ~flush:
  - clr=1: L_R0 = L_RN = 1; WB_DataIn = 0; WB_RegSel = 0.
  - dest=0: L_R0 = 1, L_RN = 0. Index 0 always uses the R0 path.
  - dest≠0: L_RN = 1, L_R0 = 0, WB_RegSel = dest.
  - Inactive: strobes are 0; WB_DataIn and WB_RegSel hold their last values.
- flush: clears v at the next posedge, suppresses the current write, and blocks capture in the same cycle.
- Forwarding. Two levels: level A is the incoming ex result (when ex_valid & ex_ready); level B is the active latch. A takes priority over B.
  - clr at any level forces a hit with data 0 for both R0 and RN.
  - RN hit: the level's dest equals rd_regsel. R0 hit: the level's dest equals 0.
  - If rd_regsel = 0, then fwd_rn_hit equals fwd_r0_hit and the two data outputs are equal.
- wb_count:
  - Increments by 1 on each posedge with an active (unflushed) write.
  - A clear-all counts as one write.
  - The INIT clear does not count.
  - Wraps from 0xFFFF to 0x0000.

## Timing
- Reset values, while rst is high: all outputs 0, state INIT, v = 0, wb_count = 0.
- rst deassertion is treated as synchronous to clk. Exactly one INIT cycle follows.
- Latency: a result captured at posedge N is written to the array at posedge N+1. It is visible through forwarding combinationally from cycle N onward.
- Throughput: one result per cycle with no bubbles.
- Simultaneous capture and write: the latch loads the new result while the old result writes. Level A forwards the new value.
- stall and flush together: no capture, no write, v cleared.
- rst asserted mid-write: the write is abandoned and strobes drop immediately. The INIT clear follows.
- The array writes on the same posedge edge. There is no WAR protection; forwarding covers read-after-write within the window.

## Structure
- Shared package contents:
  - WIDTH = 16.
  - SEL_W = 3.
  - State enum {INIT, RUN}.
  - Latch struct {v, clr, dest, data}.
- One natural sub-module: wb_fwd_unit, the purely combinational two-level forwarding comparator. The FSM, latch, decode and counter stay in wb_stage.

## Test plan
- Reset release: rst 1→0 → exactly one cycle with L_R0 = L_RN = 1 and ex_ready = 0, then RUN. wb_count stays 0.
- RN write: ex_valid, dest=5, data=0x1234 at cycle N → at N+1 L_RN=1, WB_RegSel=5, WB_DataIn=0x1234. wb_count becomes 1.
- Dest 0: dest=0, data=0xBEEF → L_R0=1, L_RN=0. With rd_regsel=0, both hits are 1 with data 0xBEEF.
- Forward priority: back-to-back writes to dest 3 of 0x0011 then 0x0022, rd_regsel=3 → in the second capture cycle fwd_rn_data = 0x0022.
- Flush and stall:
  - flush on a latched dest=4 → no strobe and the count is unchanged.
  - stall=1 with ex_valid → ex_ready=0 and nothing is written.
- Clear-all and wrap: ex_clear → L_R0 = L_RN = 1 and forwarding returns 0 for every index. With wb_count preloaded via 65535 writes, the next write wraps it to 0.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// ============================================================================
// Module  : wb_stage_pkg
// Purpose : Shared types and widths for the writeback stage and its
//           forwarding comparator.
// Contents: WIDTH / SEL_W datapath widths, FSM state type, latch record,
//           and the forwarding match helper.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_stage_pkg;

  localparam int WIDTH = 16;
  localparam int SEL_W = 3;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // One pending writeback: valid, clear-all flag, destination and value.
  typedef struct packed {
    logic             v;
    logic             clr;
    logic [SEL_W-1:0] dest;
    logic [WIDTH-1:0] data;
  } wb_latch_t;

  // A forwarding level hits a register when it is live and either clears
  // every register or targets exactly the requested one.
  function automatic logic fwd_match(
    input logic             valid,
    input logic             clr,
    input logic [SEL_W-1:0] dest,
    input logic [SEL_W-1:0] sel
  );
    return valid & (clr | (dest == sel));
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_fwd_unit.sv
// ============================================================================
// Module  : wb_fwd_unit
// Purpose : Purely combinational two-level operand forwarding. Level A is the
//           result entering the stage this cycle, level B the latched result
//           being written; A is newer and wins.
// Ports   : en                         - forwarding allowed (stage running)
//           a_valid/a_clr/a_dest/a_data - level A candidate
//           b_valid/b_clr/b_dest/b_data - level B candidate
//           rd_regsel                  - array read selector
//           rn_hit/rn_data             - override for the RN read port
//           r0_hit/r0_data             - override for the R0 read port
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_fwd_unit
  import wb_stage_pkg::*;
(
  input  logic             en,
  input  logic             a_valid,
  input  logic             a_clr,
  input  logic [SEL_W-1:0] a_dest,
  input  logic [WIDTH-1:0] a_data,
  input  logic             b_valid,
  input  logic             b_clr,
  input  logic [SEL_W-1:0] b_dest,
  input  logic [WIDTH-1:0] b_data,
  input  logic [SEL_W-1:0] rd_regsel,
  output logic             rn_hit,
  output logic [WIDTH-1:0] rn_data,
  output logic             r0_hit,
  output logic [WIDTH-1:0] r0_data
);

  logic w_a_rn;
  logic w_b_rn;
  logic w_a_r0;
  logic w_b_r0;

  assign w_a_rn = fwd_match(a_valid, a_clr, a_dest, rd_regsel);
  assign w_b_rn = fwd_match(b_valid, b_clr, b_dest, rd_regsel);
  assign w_a_r0 = fwd_match(a_valid, a_clr, a_dest, '0);
  assign w_b_r0 = fwd_match(b_valid, b_clr, b_dest, '0);

  // A clear-all level forwards zero; data outputs read zero when no hit.
  always_comb begin
    rn_hit  = 1'b0;
    rn_data = '0;
    r0_hit  = 1'b0;
    r0_data = '0;
    if (en) begin
      if (w_a_rn) begin
        rn_hit  = 1'b1;
        rn_data = a_clr ? '0 : a_data;
      end else if (w_b_rn) begin
        rn_hit  = 1'b1;
        rn_data = b_clr ? '0 : b_data;
      end

      if (w_a_r0) begin
        r0_hit  = 1'b1;
        r0_data = a_clr ? '0 : a_data;
      end else if (w_b_r0) begin
        r0_hit  = 1'b1;
        r0_data = b_clr ? '0 : b_data;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/wb_stage.sv
// ============================================================================
// Module  : wb_stage
// Purpose : Writeback stage feeding the register array write port. Latches
//           one execute result per cycle, decodes it into R0/RN load strobes,
//           forwards in-flight results to the array read selector, counts
//           retired writes, and issues a clear-all after every reset.
// Ports   : clk, rst                 - clock, async active-high reset
//           ex_valid/ex_data/ex_dest/ex_clear - incoming result
//           stall, flush             - freeze capture / kill latched result
//           ex_ready                 - stage accepts ex_valid
//           WB_DataIn/WB_RegSel      - array write data / selector
//           L_R0/L_RN                - load strobes (both = clear-all)
//           rd_regsel                - array read selector for forwarding
//           fwd_rn_hit/fwd_rn_data   - RN read override
//           fwd_r0_hit/fwd_r0_data   - R0 read override
//           wb_count                 - retired write count (wraps)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_stage
  import wb_stage_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic [WIDTH-1:0] ex_data,
  input  logic [SEL_W-1:0] ex_dest,
  input  logic             ex_clear,
  input  logic             stall,
  input  logic             flush,
  output logic             ex_ready,
  output logic [WIDTH-1:0] WB_DataIn,
  output logic [SEL_W-1:0] WB_RegSel,
  output logic             L_R0,
  output logic             L_RN,
  input  logic [SEL_W-1:0] rd_regsel,
  output logic             fwd_rn_hit,
  output logic [WIDTH-1:0] fwd_rn_data,
  output logic             fwd_r0_hit,
  output logic [WIDTH-1:0] fwd_r0_data,
  output logic [WIDTH-1:0] wb_count
);

  state_t           r_state;
  wb_latch_t        r_lat;
  logic [WIDTH-1:0] r_hold_data;
  logic [SEL_W-1:0] r_hold_sel;
  logic [WIDTH-1:0] r_count;

  logic             w_run;
  logic             w_cap;
  logic             w_active;
  logic             w_l_r0;
  logic             w_l_rn;
  logic [WIDTH-1:0] w_data;
  logic [SEL_W-1:0] w_sel;

  assign w_run    = (r_state == ST_RUN);
  assign ex_ready = w_run & ~stall;
  // flush kills both the result being written and any result arriving now.
  assign w_cap    = ex_valid & ex_ready & ~flush;
  assign w_active = w_run & r_lat.v & ~flush;

  // --------------------------------------------------------------------------
  // FSM: one INIT cycle after reset, then RUN forever.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_INIT;
    end else begin
      case (r_state)
        ST_INIT: r_state <= ST_RUN;
        ST_RUN:  r_state <= ST_RUN;
        default: r_state <= ST_INIT;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Result latch. Without a fresh capture the entry retires after one cycle,
  // so each captured result writes exactly once.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lat <= '0;
    end else if (w_cap) begin
      r_lat.v    <= 1'b1;
      r_lat.clr  <= ex_clear;
      r_lat.dest <= ex_clear ? '0 : ex_dest;
      r_lat.data <= ex_clear ? '0 : ex_data;
    end else begin
      r_lat.v <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Write decode. rst gates the INIT clear so strobes are low while reset is
  // held and drop immediately if reset lands mid-write. Data/selector keep
  // their last driven values between writes.
  // --------------------------------------------------------------------------
  always_comb begin
    w_l_r0 = 1'b0;
    w_l_rn = 1'b0;
    w_data = r_hold_data;
    w_sel  = r_hold_sel;
    if (!rst && !w_run) begin
      w_l_r0 = 1'b1;
      w_l_rn = 1'b1;
      w_data = '0;
      w_sel  = '0;
    end else if (w_active) begin
      if (r_lat.clr) begin
        w_l_r0 = 1'b1;
        w_l_rn = 1'b1;
        w_data = '0;
        w_sel  = '0;
      end else if (r_lat.dest == '0) begin
        // Index 0 always goes through the dedicated R0 path.
        w_l_r0 = 1'b1;
        w_data = r_lat.data;
        w_sel  = '0;
      end else begin
        w_l_rn = 1'b1;
        w_data = r_lat.data;
        w_sel  = r_lat.dest;
      end
    end
  end

  assign L_R0      = w_l_r0;
  assign L_RN      = w_l_rn;
  assign WB_DataIn = w_data;
  assign WB_RegSel = w_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold_data <= '0;
      r_hold_sel  <= '0;
    end else if (w_l_r0 | w_l_rn) begin
      r_hold_data <= w_data;
      r_hold_sel  <= w_sel;
    end
  end

  // Retired-write counter; the INIT clear is not a retired write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_active) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign wb_count = r_count;

  // --------------------------------------------------------------------------
  // Forwarding. A flushed result never reaches the array, so neither level
  // forwards it.
  // --------------------------------------------------------------------------
  wb_fwd_unit u_fwd (
    .en        (w_run),
    .a_valid   (w_cap),
    .a_clr     (ex_clear),
    .a_dest    (ex_dest),
    .a_data    (ex_data),
    .b_valid   (w_active),
    .b_clr     (r_lat.clr),
    .b_dest    (r_lat.dest),
    .b_data    (r_lat.data),
    .rd_regsel (rd_regsel),
    .rn_hit    (fwd_rn_hit),
    .rn_data   (fwd_rn_data),
    .r0_hit    (fwd_r0_hit),
    .r0_data   (fwd_r0_data)
  );

endmodule

`default_nettype wire
